// File: rtl/lsu_tran_ctrl.sv
// lsu_tran_ctrl: core load/store sequencer driving the bus bridge transaction interface.
// Misaligned requests finish through ERR and never touch the bridge.
module lsu_tran_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [1:0]            lsu_size_i,
    input  logic                  lsu_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_busy_o,
    output logic                  lsu_done_o,
    output logic                  lsu_err_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic [ADDR_WIDTH-1:0] transaction_addr_o,
    output logic [DATA_WIDTH-1:0] transaction_data_o,
    output logic [1:0]            transaction_size_o,
    output logic                  transaction_we_o,
    output logic                  transaction_start_o,
    output logic                  transaction_clear_ready_o,
    input  logic                  transaction_ready_i,
    input  logic [DATA_WIDTH-1:0] transaction_data_i
);
    typedef enum logic [2:0] {IDLE, START, WAIT, RESP, ERR} state_t;
    state_t state, nxt;
    logic misaligned, uns;
    logic [DATA_WIDTH-1:0] wmask, rfmt;
    always_comb begin
        misaligned = (lsu_size_i == 2'd1 && lsu_addr_i[0]) || (lsu_size_i[1] && lsu_addr_i[1:0] != 2'b00);
        wmask = lsu_size_i == 2'd0 ? {{(DATA_WIDTH-8){1'b0}}, lsu_wdata_i[7:0]} :
                lsu_size_i == 2'd1 ? {{(DATA_WIDTH-16){1'b0}}, lsu_wdata_i[15:0]} : lsu_wdata_i;
        rfmt = transaction_size_o == 2'd0 ? {{(DATA_WIDTH-8){~uns & transaction_data_i[7]}}, transaction_data_i[7:0]} :
               transaction_size_o == 2'd1 ? {{(DATA_WIDTH-16){~uns & transaction_data_i[15]}}, transaction_data_i[15:0]} :
               transaction_data_i;
        nxt = state;
        case (state)
            IDLE:    nxt = !lsu_req_i ? IDLE : misaligned ? ERR : START;
            START:   nxt = WAIT;
            WAIT:    nxt = transaction_ready_i ? RESP : WAIT;
            default: nxt = IDLE;
        endcase
    end
    // Outputs are computed from the next state so every one of them leaves a flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                     <= IDLE;
            uns                       <= 1'b0;
            lsu_busy_o                <= 1'b0;
            lsu_done_o                <= 1'b0;
            lsu_err_o                 <= 1'b0;
            lsu_rdata_o               <= '0;
            transaction_addr_o        <= '0;
            transaction_data_o        <= '0;
            transaction_size_o        <= '0;
            transaction_we_o          <= 1'b0;
            transaction_start_o       <= 1'b0;
            transaction_clear_ready_o <= 1'b0;
        end else begin
            state                     <= nxt;
            lsu_busy_o                <= nxt != IDLE;
            lsu_done_o                <= nxt == RESP || nxt == ERR;
            lsu_err_o                 <= nxt == ERR;
            transaction_start_o       <= nxt == START;
            transaction_clear_ready_o <= nxt == RESP;
            if (state == IDLE && nxt == START) begin
                transaction_addr_o <= lsu_addr_i;
                transaction_data_o <= wmask;
                transaction_size_o <= lsu_size_i;
                transaction_we_o   <= lsu_we_i;
                uns                <= lsu_unsigned_i;
            end
            if (state == WAIT && transaction_ready_i && !transaction_we_o)
                lsu_rdata_o <= rfmt;
        end
    end
endmodule
